pipeline_ctrl: RTL and testbench

//  Parametrised stage-enable/flush controller for the N-stage pipelined datapath.

---
 rtl/pipe_ctrl_pkg.sv | 23 ++
 rtl/sat_counter.sv | 24 ++
 rtl/pipeline_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared stage indices, selector type and default freeze mask for the pipeline
// enable/flush controller.
package pipe_ctrl_pkg;

  localparam int NSTAGES_DEF = 5;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  typedef logic [3:0] stage_idx_t;

  // Result of a highest-index priority search over per-stage request bits.
  typedef struct packed {
    logic       hit;
    stage_idx_t idx;
  } stage_sel_t;

  localparam logic [NSTAGES_DEF-1:0] FREEZE_MASK_DEF = 5'b01000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters; holds at
// all-ones and stops counting while halt is high.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  input  logic             halt,
  output logic [CNT_W-1:0] q
);

  // Count register with saturation at all-ones.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      q <= '0;
    end else if (inc && !halt && !(&q)) begin
      q <= q + CNT_W'(1);
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stage-enable/flush controller: drives en/zero of every pipeline latch from
// stall/flush requests, tracks per-latch valid bits, sticky halt and counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int                  NSTAGES     = NSTAGES_DEF,
  parameter int                  CNT_W       = 32,
  parameter logic [NSTAGES-1:0]  FREEZE_MASK = FREEZE_MASK_DEF
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [NSTAGES-1:0] stall_req,
  input  logic [NSTAGES-1:0] flush_req,
  input  logic               halt_in,
  output logic [NSTAGES-2:0] stage_en,
  output logic [NSTAGES-2:0] stage_zero,
  output logic [NSTAGES-2:0] stage_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   cyc_cnt,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic [CNT_W-1:0]   retire_cnt
);

  localparam int NL = NSTAGES - 1;

  function automatic stage_sel_t find_oldest(input logic [NSTAGES-1:0] req);
    stage_sel_t sel;
    sel = '0;
    for (int i = 0; i < NSTAGES; i++) begin
      if (req[i]) begin
        sel.hit = 1'b1;
        sel.idx = stage_idx_t'(i);
      end
    end
    return sel;
  endfunction

  stage_sel_t    stall_sel_s;
  stage_sel_t    flush_sel_s;
  logic          active_s;
  logic          freeze_s;
  logic [NL-1:0] en_s;
  logic [NL-1:0] zero_s;
  logic          eff_vld_s;
  stage_idx_t    eff_idx_s;
  logic          in_range_s;
  logic          all_en_s;
  logic          apply_s;
  logic          pend_vld_nxt_s;
  stage_idx_t    pend_f_nxt_s;
  logic [NL-1:0] prev_valid_s;

  logic          halted_r;
  logic          pend_vld_r;
  stage_idx_t    pend_f_r;
  logic [NL-1:0] valid_r;

  // Latch enables/bubbles and pending-flush bookkeeping for the current cycle.
  always_comb begin
    stall_sel_s    = find_oldest(stall_req);
    flush_sel_s    = find_oldest(flush_req);
    active_s       = nRST && !halted_r;
    freeze_s       = 1'b0;
    en_s           = '0;
    zero_s         = '0;
    eff_vld_s      = 1'b0;
    eff_idx_s      = '0;
    in_range_s     = 1'b0;
    all_en_s       = 1'b1;
    apply_s        = 1'b0;
    pend_vld_nxt_s = pend_vld_r;
    pend_f_nxt_s   = pend_f_r;

    for (int i = 0; i < NSTAGES; i++) begin
      freeze_s = freeze_s | (FREEZE_MASK[i] & stall_sel_s.hit &
                             (int'(stall_sel_s.idx) == i));
    end

    if (!active_s) begin
      en_s = '0;
    end else if (!stall_sel_s.hit) begin
      en_s = '1;
    end else if (freeze_s) begin
      en_s = '0;
    end else begin
      // Younger latches hold, the stalled stage's output latch takes a bubble.
      for (int k = 0; k < NL; k++) begin
        en_s[k]   = (k >= int'(stall_sel_s.idx));
        zero_s[k] = (k == int'(stall_sel_s.idx));
      end
    end

    // A pending flush survives unless a new request is at least as old.
    if (pend_vld_r && !(flush_sel_s.hit && (flush_sel_s.idx >= pend_f_r))) begin
      eff_vld_s = active_s;
      eff_idx_s = pend_f_r;
    end else begin
      eff_vld_s = active_s && flush_sel_s.hit;
      eff_idx_s = flush_sel_s.idx;
    end

    for (int k = 0; k < NL; k++) begin
      in_range_s = eff_vld_s && (k < int'(eff_idx_s));
      zero_s[k]  = zero_s[k] | (in_range_s & en_s[k]);
      all_en_s   = all_en_s & (!in_range_s | en_s[k]);
    end
    apply_s = eff_vld_s && all_en_s;

    if (apply_s) begin
      pend_vld_nxt_s = 1'b0;
      pend_f_nxt_s   = '0;
    end else if (eff_vld_s) begin
      pend_vld_nxt_s = 1'b1;
      pend_f_nxt_s   = eff_idx_s;
    end else begin
      pend_vld_nxt_s = pend_vld_r;
      pend_f_nxt_s   = pend_f_r;
    end
  end

  assign prev_valid_s = {valid_r[NL-2:0], 1'b1};

  // Halt, pending flush and per-latch valid state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      halted_r   <= 1'b0;
      pend_vld_r <= 1'b0;
      pend_f_r   <= '0;
      valid_r    <= '0;
    end else begin
      halted_r   <= halted_r | halt_in;
      pend_vld_r <= pend_vld_nxt_s;
      pend_f_r   <= pend_f_nxt_s;
      for (int k = 0; k < NL; k++) begin
        if (en_s[k]) begin
          valid_r[k] <= !zero_s[k] && prev_valid_s[k];
        end else begin
          valid_r[k] <= valid_r[k];
        end
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cyc (
    .CLK(CLK), .nRST(nRST), .inc(1'b1), .halt(halted_r), .q(cyc_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .CLK(CLK), .nRST(nRST), .inc(|stall_req), .halt(halted_r), .q(stall_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush (
    .CLK(CLK), .nRST(nRST), .inc(apply_s), .halt(halted_r), .q(flush_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_retire (
    .CLK(CLK), .nRST(nRST), .inc(en_s[NL-1] & valid_r[NL-1]), .halt(halted_r),
    .q(retire_cnt)
  );

  assign stage_en    = en_s;
  assign stage_zero  = zero_s;
  assign stage_valid = valid_r;
  assign halted      = halted_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, halt/reset sequences and a
// randomized phase against a pipeline-occupancy reference model.
module tb_pipeline_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int NS  = 5;
  localparam int NL  = 4;
  localparam int CW  = 8;
  localparam int LIM = 255;
  localparam logic [NS-1:0] FMASK = 5'b01000;

  logic          CLK = 1'b0;
  logic          nRST;
  logic [NS-1:0] stall_req;
  logic [NS-1:0] flush_req;
  logic          halt_in;
  logic [NL-1:0] stage_en;
  logic [NL-1:0] stage_zero;
  logic [NL-1:0] stage_valid;
  logic          halted;
  logic [CW-1:0] cyc_cnt;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
  logic [CW-1:0] retire_cnt;

  pipeline_ctrl #(.NSTAGES(NS), .CNT_W(CW), .FREEZE_MASK(FMASK)) dut (
    .CLK(CLK), .nRST(nRST), .stall_req(stall_req), .flush_req(flush_req),
    .halt_in(halt_in), .stage_en(stage_en), .stage_zero(stage_zero),
    .stage_valid(stage_valid), .halted(halted), .cyc_cnt(cyc_cnt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [NS-1:0] stall;
    logic [NS-1:0] flush;
    logic [NL-1:0] en;
    logic [NL-1:0] zero;
    logic [NL-1:0] valid;
  } vec_t;

  vec_t tbl[13];

  task automatic run_vec(input int i, input vec_t v);
    stall_req = v.stall;
    flush_req = v.flush;
    halt_in   = 1'b0;
    #1;
    chk($sformatf("vec%0d_en", i), 32'(stage_en), 32'(v.en));
    chk($sformatf("vec%0d_zero", i), 32'(stage_zero), 32'(v.zero));
    @(posedge CLK);
    #1;
    chk($sformatf("vec%0d_valid", i), 32'(stage_valid), 32'(v.valid));
    @(negedge CLK);
  endtask

  // Reference model: occupancy bits of the four latches plus counters.
  logic [NL-1:0] m_valid;
  bit            m_halted;
  int            m_pend;
  int            m_cyc, m_stall, m_flush, m_retire;

  function automatic int sat_inc(input int x);
    return (x < LIM) ? x + 1 : x;
  endfunction

  task automatic model_reset();
    m_valid = '0; m_halted = 1'b0; m_pend = -1;
    m_cyc = 0; m_stall = 0; m_flush = 0; m_retire = 0;
  endtask

  task automatic model_step(input logic [NS-1:0] st, input logic [NS-1:0] fl,
                            input logic h, output logic [NL-1:0] e, output logic [NL-1:0] z);
    int s, f, eff;
    bit all_en;
    logic [NL:0] prev;
    e = '0; z = '0;
    if (m_halted) return;
    s = -1; f = -1;
    for (int i = 0; i < NS; i++) begin
      if (st[i]) s = i;
      if (fl[i]) f = i;
    end
    if (s < 0) e = '1;
    else if (FMASK[s]) e = '0;
    else begin
      for (int k = s; k < NL; k++) e[k] = 1'b1;
      if (s < NL) z[s] = 1'b1;
    end
    eff = (m_pend > f) ? m_pend : f;
    if (eff >= 0) begin
      all_en = 1'b1;
      for (int k = 0; k < eff && k < NL; k++) begin
        if (e[k]) z[k] = 1'b1;
        else all_en = 1'b0;
      end
      if (all_en) begin
        m_flush = sat_inc(m_flush);
        m_pend  = -1;
      end else begin
        m_pend = eff;
      end
    end
    if (e[NL-1] && m_valid[NL-1]) m_retire = sat_inc(m_retire);
    if (st != '0) m_stall = sat_inc(m_stall);
    m_cyc = sat_inc(m_cyc);
    prev = {m_valid, 1'b1};
    for (int k = 0; k < NL; k++) begin
      if (e[k]) m_valid[k] = !z[k] && prev[k];
    end
    if (h) m_halted = 1'b1;
  endtask

  initial begin
    logic [NL-1:0] me, mz;
    logic [NS-1:0] st, fl;

    tbl[0]  = '{5'b00000, 5'b00000, 4'b1111, 4'b0000, 4'b0001};
    tbl[1]  = '{5'b00000, 5'b00000, 4'b1111, 4'b0000, 4'b0011};
    tbl[2]  = '{5'b00000, 5'b00000, 4'b1111, 4'b0000, 4'b0111};
    tbl[3]  = '{5'b00000, 5'b00000, 4'b1111, 4'b0000, 4'b1111};
    tbl[4]  = '{5'b00000, 5'b00000, 4'b1111, 4'b0000, 4'b1111};
    tbl[5]  = '{5'b00000, 5'b00000, 4'b1111, 4'b0000, 4'b1111};
    tbl[6]  = '{5'b00100, 5'b00000, 4'b1100, 4'b0100, 4'b1011};
    tbl[7]  = '{5'b00100, 5'b00000, 4'b1100, 4'b0100, 4'b0011};
    tbl[8]  = '{5'b00000, 5'b00000, 4'b1111, 4'b0000, 4'b0111};
    tbl[9]  = '{5'b01000, 5'b00000, 4'b0000, 4'b0000, 4'b0111};
    tbl[10] = '{5'b01000, 5'b00000, 4'b0000, 4'b0000, 4'b0111};
    tbl[11] = '{5'b01000, 5'b00100, 4'b0000, 4'b0000, 4'b0111};
    tbl[12] = '{5'b00000, 5'b00000, 4'b1111, 4'b0011, 4'b1100};

    // Reset with live requests: outputs must stay quiet.
    nRST = 1'b0; stall_req = 5'b00001; flush_req = 5'b00100; halt_in = 1'b1;
    #12;
    chk("rst_en", 32'(stage_en), 32'h0);
    chk("rst_zero", 32'(stage_zero), 32'h0);
    chk("rst_valid", 32'(stage_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_cyc", 32'(cyc_cnt), 32'h0);
    chk("rst_flush", 32'(flush_cnt), 32'h0);
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i, tbl[i]);
    chk("fill_cyc", 32'(cyc_cnt), 32'd6);
    chk("fill_retire", 32'(retire_cnt), 32'd2);
    for (int i = 6; i < 13; i++) run_vec(i, tbl[i]);
    chk("dir_stall_cnt", 32'(stall_cnt), 32'd5);
    chk("dir_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("dir_cyc", 32'(cyc_cnt), 32'd13);
    chk("dir_retire", 32'(retire_cnt), 32'd4);

    // Halt: one-cycle pulse, then everything frozen despite stimulus.
    stall_req = '0; flush_req = '0; halt_in = 1'b1;
    #1;
    chk("halt_cycle_en", 32'(stage_en), 32'hf);
    @(posedge CLK); #1;
    chk("halt_set", 32'(halted), 32'h1);
    chk("halt_valid", 32'(stage_valid), 32'h9);
    @(negedge CLK);
    halt_in = 1'b0;
    for (int c = 0; c < 10; c++) begin
      stall_req = 5'($urandom_range(0, 31));
      flush_req = 5'($urandom_range(0, 31));
      halt_in   = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("halted%0d_en", c), 32'(stage_en), 32'h0);
      chk($sformatf("halted%0d_zero", c), 32'(stage_zero), 32'h0);
      @(posedge CLK); #1;
      chk($sformatf("halted%0d_cyc", c), 32'(cyc_cnt), 32'd14);
      chk($sformatf("halted%0d_valid", c), 32'(stage_valid), 32'h9);
      @(negedge CLK);
    end
    chk("halted_stall_cnt", 32'(stall_cnt), 32'd5);
    chk("halted_flag", 32'(halted), 32'h1);

    // Randomized phase against the reference model; long enough to saturate cyc_cnt.
    stall_req = '0; flush_req = '0; halt_in = 1'b0;
    nRST = 1'b0;
    #2;
    @(negedge CLK);
    nRST = 1'b1;
    model_reset();
    for (int c = 0; c < 300; c++) begin
      for (int b = 0; b < NS; b++) st[b] = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 5) == 0) fl = {4'($urandom_range(1, 15)), 1'b0};
      else fl = '0;
      stall_req = st; flush_req = fl; halt_in = 1'b0;
      model_step(st, fl, 1'b0, me, mz);
      #1;
      chk($sformatf("rnd%0d_en", c), 32'(stage_en), 32'(me));
      chk($sformatf("rnd%0d_zero", c), 32'(stage_zero), 32'(mz));
      @(posedge CLK); #1;
      chk($sformatf("rnd%0d_valid", c), 32'(stage_valid), 32'(m_valid));
      chk($sformatf("rnd%0d_cyc", c), 32'(cyc_cnt), 32'(m_cyc));
      chk($sformatf("rnd%0d_stall", c), 32'(stall_cnt), 32'(m_stall));
      chk($sformatf("rnd%0d_flush", c), 32'(flush_cnt), 32'(m_flush));
      chk($sformatf("rnd%0d_retire", c), 32'(retire_cnt), 32'(m_retire));
      @(negedge CLK);
    end
    chk("cyc_saturated", 32'(cyc_cnt), 32'hff);

    // Asynchronous reset in the middle of a stall.
    stall_req = 5'b00100; flush_req = 5'b00010; halt_in = 1'b0;
    #2;
    nRST = 1'b0;
    #1;
    chk("midrst_en", 32'(stage_en), 32'h0);
    chk("midrst_zero", 32'(stage_zero), 32'h0);
    chk("midrst_valid", 32'(stage_valid), 32'h0);
    chk("midrst_cyc", 32'(cyc_cnt), 32'h0);
    chk("midrst_stall", 32'(stall_cnt), 32'h0);
    chk("midrst_retire", 32'(retire_cnt), 32'h0);
    @(negedge CLK);
    nRST = 1'b1; stall_req = '0; flush_req = '0;
    #1;
    chk("post_rst_en", 32'(stage_en), 32'hf);
    chk("post_rst_zero", 32'(stage_zero), 32'h0);
    @(posedge CLK); #1;
    chk("post_rst_valid", 32'(stage_valid), 32'h1);
    chk("post_rst_cyc", 32'(cyc_cnt), 32'h1);
    chk("post_rst_flush", 32'(flush_cnt), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
